// File: rtl/sprite_line_scanner_if.sv
// sprite_line_scanner_if: attribute-table read bus between scanner (master) and attribute RAM (slave)
interface sprite_line_scanner_if #(
    parameter int SPRITE_COUNT = 512,
    parameter int Y_W          = 11,
    parameter int H_W          = 4,
    parameter int PAYLOAD_W    = 48
);
    localparam int IDX_W = $clog2(SPRITE_COUNT);
    logic [IDX_W-1:0]     attr_index;
    logic [Y_W-1:0]       attr_y;
    logic [H_W-1:0]       attr_height;
    logic                 attr_yflip;
    logic [PAYLOAD_W-1:0] attr_payload;
    modport master (output attr_index, input attr_y, attr_height, attr_yflip, attr_payload);
    modport slave  (input attr_index, output attr_y, attr_height, attr_yflip, attr_payload);
endinterface

// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner: per-scanline sprite list builder with a three-bank build/pending/display ring
module sprite_line_scanner #(
    parameter int SPRITE_COUNT = 512,
    parameter int MAX_PER_LINE = 64,
    parameter int Y_W          = 11,
    parameter int H_W          = 4,
    parameter int HEIGHT_SHIFT = 4,
    parameter int PAYLOAD_W    = 48,
    localparam int IDX_W = $clog2(SPRITE_COUNT),
    localparam int CNT_W = $clog2(MAX_PER_LINE + 1),
    localparam int ROW_W = H_W + HEIGHT_SHIFT
) (
    input  logic                  clk_draw,
    input  logic                  rst_draw,
    input  logic                  enable_i,
    input  logic                  line_i,
    input  logic [Y_W-1:0]        target_y_i,
    sprite_line_scanner_if.master attr_if,
    input  logic [CNT_W-1:0]      rd_index_i,
    output logic                  rd_valid_o,
    output logic [PAYLOAD_W-1:0]  rd_payload_o,
    output logic [ROW_W-1:0]      rd_row_o,
    output logic [CNT_W-1:0]      active_count_o,
    output logic                  overflow_o,
    output logic                  late_o,
    output logic                  scan_busy_o
);
    localparam int SLOT_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int ENT_W  = PAYLOAD_W + ROW_W;
    localparam int CMP_W  = (Y_W + 1 > ROW_W) ? Y_W + 1 : ROW_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPRITE_COUNT - 1);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(MAX_PER_LINE);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         disp;
    logic [CNT_W-1:0]   cnt_q  [3];
    logic               ovf_q  [3];
    logic               late_q [3];
    logic [ENT_W-1:0]   mem_q  [3][MAX_PER_LINE];
    logic               rd_valid_q;
    logic [PAYLOAD_W-1:0] rd_payload_q;
    logic [ROW_W-1:0]   rd_row_q;
    logic [Y_W:0]       d;
    logic [CMP_W-1:0]   span;
    logic [ROW_W-1:0]   row;
    logic               hit, wr_en, ovf_set;
    logic [SLOT_W-1:0]  wr_slot, rd_slot;
    logic [ENT_W-1:0]   rd_ent;

    // The bank after the build bank is both the one on display and the next build bank
    assign disp = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;

    // Match in Y_W+1 bits so a sprite below the target never wraps into range
    assign d       = {1'b0, target_y_i} - {1'b0, attr_if.attr_y};
    assign span    = CMP_W'(attr_if.attr_height) << HEIGHT_SHIFT;
    assign hit     = valid_q && !line_i && enable_i && (target_y_i >= attr_if.attr_y) && (CMP_W'(d) < span);
    assign row     = attr_if.attr_yflip ? ROW_W'(span - CMP_W'(d) - CMP_W'(1)) : ROW_W'(d);
    assign wr_en   = hit && (cnt_q[ptr_q] < CAP);
    assign ovf_set = hit && (cnt_q[ptr_q] == CAP);
    assign wr_slot = cnt_q[ptr_q][SLOT_W-1:0];
    assign rd_slot = rd_index_i[SLOT_W-1:0];
    assign rd_ent  = mem_q[disp][rd_slot];

    assign attr_if.attr_index = idx_q;
    assign active_count_o     = cnt_q[disp];
    assign overflow_o         = ovf_q[disp];
    assign late_o             = late_q[disp];
    assign scan_busy_o        = state_q != IDLE;
    assign rd_valid_o         = rd_valid_q;
    assign rd_payload_o       = rd_payload_q;
    assign rd_row_o           = rd_row_q;

    // Scan state, attribute address, data-valid pipeline and bank pointer
    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: a line pulse always restarts the scan and rotates the ring
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        ptr_d   = ptr_q;
        if (line_i) begin
            state_d = SCAN;
            idx_d   = '0;
            ptr_d   = disp;
        end else if (state_q == SCAN) begin
            state_d = (idx_q == LAST_IDX) ? DRAIN : SCAN;
            idx_d   = (idx_q == LAST_IDX) ? idx_q : idx_q + IDX_W'(1);
            valid_d = 1'b1;
        end else if (state_q == DRAIN) begin
            state_d = IDLE;
        end
    end

    // Per-bank count and flags; an interrupted scan marks its bank late before it rotates
    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            for (int b = 0; b < 3; b++) begin
                cnt_q[b]  <= '0;
                ovf_q[b]  <= 1'b0;
                late_q[b] <= 1'b0;
            end
        end else if (line_i) begin
            late_q[ptr_q] <= state_q != IDLE;
            cnt_q[disp]   <= '0;
            ovf_q[disp]   <= 1'b0;
            late_q[disp]  <= 1'b0;
        end else begin
            if (wr_en) cnt_q[ptr_q] <= cnt_q[ptr_q] + CNT_W'(1);
            if (ovf_set) ovf_q[ptr_q] <= 1'b1;
        end
    end

    // Entry storage: appended in sprite order into the build bank
    always_ff @(posedge clk_draw) begin
        if (wr_en) mem_q[ptr_q][wr_slot] <= {attr_if.attr_payload, row};
    end

    // Registered read port on the display bank; empty slots read as zero
    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            rd_valid_q   <= 1'b0;
            rd_payload_q <= '0;
            rd_row_q     <= '0;
        end else begin
            rd_valid_q   <= rd_index_i < cnt_q[disp];
            rd_payload_q <= (rd_index_i < cnt_q[disp]) ? rd_ent[ENT_W-1:ROW_W] : '0;
            rd_row_q     <= (rd_index_i < cnt_q[disp]) ? rd_ent[ROW_W-1:0] : '0;
        end
    end
endmodule

// File: tb/tb_sprite_line_scanner.sv
// tb_sprite_line_scanner: directed line sequence with a scoreboard of expected display lists
module tb_sprite_line_scanner;
    localparam int SC    = 512;
    localparam int MAXL  = 64;
    localparam int Y_W   = 11;
    localparam int H_W   = 4;
    localparam int HS    = 4;
    localparam int PW    = 48;
    localparam int CNT_W = $clog2(MAXL + 1);
    localparam int ROW_W = H_W + HS;
    localparam int ENT_W = PW + ROW_W;

    logic             clk_draw = 1'b0;
    logic             rst_draw = 1'b1;
    logic             enable   = 1'b0;
    logic             line     = 1'b0;
    logic [Y_W-1:0]   target_y = '0;
    logic [CNT_W-1:0] rd_index = '0;
    logic             rd_valid;
    logic [PW-1:0]    rd_payload;
    logic [ROW_W-1:0] rd_row;
    logic [CNT_W-1:0] active_count;
    logic             overflow, late, scan_busy;

    logic [Y_W-1:0] tbl_y [SC];
    logic [H_W-1:0] tbl_h [SC];
    logic           tbl_f [SC];
    logic [PW-1:0]  tbl_p [SC];

    int errors = 0;
    int checks = 0;
    int exp_cnt[$];
    bit exp_ovf[$];
    bit exp_late[$];
    logic [ENT_W-1:0] exp_ent[$];

    sprite_line_scanner_if #(.SPRITE_COUNT(SC), .Y_W(Y_W), .H_W(H_W), .PAYLOAD_W(PW)) aif ();

    sprite_line_scanner #(
        .SPRITE_COUNT(SC), .MAX_PER_LINE(MAXL), .Y_W(Y_W), .H_W(H_W), .HEIGHT_SHIFT(HS), .PAYLOAD_W(PW)
    ) dut (
        .clk_draw(clk_draw), .rst_draw(rst_draw), .enable_i(enable), .line_i(line),
        .target_y_i(target_y), .attr_if(aif), .rd_index_i(rd_index),
        .rd_valid_o(rd_valid), .rd_payload_o(rd_payload), .rd_row_o(rd_row),
        .active_count_o(active_count), .overflow_o(overflow), .late_o(late), .scan_busy_o(scan_busy)
    );

    always #5 clk_draw = ~clk_draw;

    // Attribute RAM with one-cycle read latency
    always @(posedge clk_draw) begin
        aif.attr_y       <= tbl_y[aif.attr_index];
        aif.attr_height  <= tbl_h[aif.attr_index];
        aif.attr_yflip   <= tbl_f[aif.attr_index];
        aif.attr_payload <= tbl_p[aif.attr_index];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input int i, input int ty);
        int span = int'(tbl_h[i]) << HS;
        return (ty >= int'(tbl_y[i])) && (ty - int'(tbl_y[i]) < span);
    endfunction

    function automatic logic [ROW_W-1:0] m_row(input int i, input int ty);
        int span = int'(tbl_h[i]) << HS;
        int d = ty - int'(tbl_y[i]);
        return ROW_W'(tbl_f[i] ? span - 1 - d : d);
    endfunction

    task automatic clear_tbl();
        for (int i = 0; i < SC; i++) begin
            tbl_y[i] = '0;
            tbl_h[i] = '0;
            tbl_f[i] = 1'b0;
            tbl_p[i] = {16'(i * 37 + 5), 32'(i)};
        end
    endtask

    task automatic push_empty();
        exp_cnt.push_back(0);
        exp_ovf.push_back(1'b0);
        exp_late.push_back(1'b0);
    endtask

    // Pulse line, predict this line's list, check the list built two pulses ago, then idle to gap cycles
    task automatic do_line(input int ty, input bit en, input int gap);
        int n, c, used;
        bit o;
        logic [ENT_W-1:0] e;
        @(negedge clk_draw);
        line = 1'b1;
        target_y = Y_W'(ty);
        enable = en;
        n = (gap >= SC + 2) ? SC : gap - 2;
        c = 0;
        o = 1'b0;
        for (int i = 0; i < n; i++)
            if (en && m_hit(i, ty)) begin
                if (c < MAXL) begin
                    exp_ent.push_back({tbl_p[i], m_row(i, ty)});
                    c++;
                end else o = 1'b1;
            end
        exp_cnt.push_back(c);
        exp_ovf.push_back(o);
        exp_late.push_back(gap < SC + 2);
        @(negedge clk_draw);
        line = 1'b0;
        chk("scan_busy_on", scan_busy, 1);
        c = exp_cnt.pop_front();
        chk("active_count", active_count, c);
        chk("overflow", overflow, exp_ovf.pop_front());
        chk("late", late, exp_late.pop_front());
        used = 0;
        for (int s = 0; s <= c; s++) begin
            rd_index = CNT_W'(s);
            @(negedge clk_draw);
            used++;
            chk("rd_valid", rd_valid, s < c);
            if (s < c) begin
                e = exp_ent.pop_front();
                chk("rd_payload", rd_payload, e[ENT_W-1:ROW_W]);
                chk("rd_row", rd_row, e[ROW_W-1:0]);
            end
        end
        repeat (gap - 2 - used) @(negedge clk_draw);
        if (gap >= SC + 8) chk("scan_busy_off", scan_busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_payload"}, rd_payload, 0);
        chk({tag, "_rd_row"}, rd_row, 0);
        chk({tag, "_active_count"}, active_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_late"}, late, 0);
        chk({tag, "_scan_busy"}, scan_busy, 0);
        chk({tag, "_attr_index"}, aif.attr_index, 0);
    endtask

    initial begin
        clear_tbl();
        push_empty();
        push_empty();
        repeat (2) @(negedge clk_draw);
        chk_reset_vals("reset");
        rst_draw = 1'b0;
        tbl_y[0] = 11'd100; tbl_h[0] = 4'd1;
        tbl_y[1] = 11'd110; tbl_h[1] = 4'd2;
        tbl_y[2] = 11'd200; tbl_h[2] = 4'd1;
        do_line(115, 1'b1, 520);
        clear_tbl();
        tbl_y[0] = 11'd100; tbl_h[0] = 4'd2; tbl_f[0] = 1'b1;
        do_line(100, 1'b1, 520);
        do_line(131, 1'b1, 520);
        do_line(132, 1'b1, 520);
        do_line(99, 1'b1, 520);
        tbl_h[0] = 4'd0;
        do_line(100, 1'b1, 520);
        clear_tbl();
        for (int i = 0; i < MAXL + 5; i++) begin
            tbl_y[i] = 11'd50;
            tbl_h[i] = 4'd1;
        end
        do_line(55, 1'b1, 520);
        clear_tbl();
        for (int i = 0; i < SC; i += 8) begin
            tbl_y[i] = 11'd10;
            tbl_h[i] = 4'd1;
        end
        do_line(12, 1'b0, 520);
        do_line(12, 1'b1, 100);
        do_line(12, 1'b1, 520);
        do_line(12, 1'b1, 520);
        do_line(12, 1'b1, 301);
        rd_index = '0;
        @(negedge clk_draw);
        chk("pre_reset_rd_valid", rd_valid, 1);
        rst_draw = 1'b1;
        #1;
        chk_reset_vals("midscan_reset");
        exp_cnt.delete();
        exp_ovf.delete();
        exp_late.delete();
        exp_ent.delete();
        push_empty();
        push_empty();
        @(negedge clk_draw);
        rst_draw = 1'b0;
        clear_tbl();
        tbl_y[0] = 11'd100; tbl_h[0] = 4'd1;
        tbl_y[1] = 11'd110; tbl_h[1] = 4'd2;
        tbl_y[2] = 11'd200; tbl_h[2] = 4'd1;
        do_line(115, 1'b1, 520);
        do_line(0, 1'b1, 520);
        do_line(0, 1'b1, 520);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
